sum_display_scanner: RTL and testbench

Downstream display stage for the 4-bit ripple-carry adder: consumes the 5-bit sum and drives the board's 4-digit multiplexed active-low 7-segment display. Digits 1:0 show the sum in decimal. Digits 3:2 show it in hex. The sum is snapshotted once per scan frame so that a frame never mixes two values. Inter-digit blanking suppresses ghosting. This block replaces the separate decoder, clock divider and digit switcher with one clocked block.

---
 rtl/sum_display_scanner_if.sv | 8 +
 rtl/sum_display_scanner.sv | 73 +++++++
 tb/tb_sum_display_scanner.sv | 70 +++++++
 3 files changed

// File: rtl/sum_display_scanner_if.sv
// sum_display_scanner_if: adder sum in, multiplexed 7-segment drive out
interface sum_display_scanner_if;
  logic [4:0] sum;
  logic [7:0] seg;
  logic [3:0] anode;
  modport master (output sum, input seg, anode);
  modport slave (input sum, output seg, anode);
endinterface

// File: rtl/sum_display_scanner.sv
// sum_display_scanner: shows a 5-bit sum as decimal (digits 1:0) and hex (digits 3:2)
// on a 4-digit active-low display, one snapshot per scan frame, with inter-digit blanking
module sum_display_scanner #(
  parameter int CLK_DIV = 50000,
  parameter int BLANK_CYC = 16
) (
  input logic mclk,
  input logic rs,
  sum_display_scanner_if.slave bus
);
  localparam int W = $clog2(CLK_DIV);
  logic [W-1:0] cnt_q, cnt_d, blank_q, blank_d;
  logic [1:0] idx_q, idx_d, tens;
  logic [4:0] snap_q, snap_d;
  logic live_q, live_d, tick, dark;
  logic [7:0] seg_q, seg_d;
  logic [3:0] anode_q, anode_d, units, nib;
  function automatic logic [7:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 8'hC0;
      4'h1: seg7 = 8'hF9;
      4'h2: seg7 = 8'hA4;
      4'h3: seg7 = 8'hB0;
      4'h4: seg7 = 8'h99;
      4'h5: seg7 = 8'h92;
      4'h6: seg7 = 8'h82;
      4'h7: seg7 = 8'hF8;
      4'h8: seg7 = 8'h80;
      4'h9: seg7 = 8'h90;
      4'hA: seg7 = 8'h88;
      4'hB: seg7 = 8'h83;
      4'hC: seg7 = 8'hC6;
      4'hD: seg7 = 8'hA1;
      4'hE: seg7 = 8'h86;
      default: seg7 = 8'h8E;
    endcase
  endfunction
  // Outputs are computed from next-state values so they change on the same edge as the state
  always_comb begin
    tick = cnt_q == W'(CLK_DIV - 1);
    cnt_d = tick ? '0 : cnt_q + W'(1);
    idx_d = tick ? idx_q + 2'd1 : idx_q;
    snap_d = (tick && idx_q == 2'd3) ? bus.sum : snap_q;
    blank_d = tick ? W'(BLANK_CYC) : (blank_q != '0 ? blank_q - W'(1) : blank_q);
    live_d = live_q | tick;
    tens = snap_d >= 5'd30 ? 2'd3 : snap_d >= 5'd20 ? 2'd2 : snap_d >= 5'd10 ? 2'd1 : 2'd0;
    units = 4'(snap_d - 5'(tens) * 5'd10);
    nib = idx_d == 2'd0 ? units : idx_d == 2'd1 ? {2'b00, tens} : idx_d == 2'd2 ? snap_d[3:0] : {3'b000, snap_d[4]};
    dark = !live_d || blank_d != '0;
    seg_d = (dark || (idx_d == 2'd1 && tens == 2'd0)) ? 8'hFF : seg7(nib);
    anode_d = dark ? 4'hF : ~(4'b0001 << idx_d);
  end
  always_ff @(posedge mclk or posedge rs)
    if (rs) begin
      cnt_q <= '0;
      blank_q <= '0;
      idx_q <= 2'd3;
      snap_q <= '0;
      live_q <= 1'b0;
      seg_q <= 8'hFF;
      anode_q <= 4'hF;
    end else begin
      cnt_q <= cnt_d;
      blank_q <= blank_d;
      idx_q <= idx_d;
      snap_q <= snap_d;
      live_q <= live_d;
      seg_q <= seg_d;
      anode_q <= anode_d;
    end
  assign bus.seg = seg_q;
  assign bus.anode = anode_q;
endmodule

// File: tb/tb_sum_display_scanner.sv
// tb_sum_display_scanner: directed frame-by-frame checks with CLK_DIV=8, BLANK_CYC=2
module tb_sum_display_scanner;
  logic mclk = 1'b0;
  logic rs = 1'b1;
  int checks = 0;
  int errors = 0;
  sum_display_scanner_if bus();
  sum_display_scanner #(.CLK_DIV(8), .BLANK_CYC(2)) dut (.mclk(mclk), .rs(rs), .bus(bus.slave));
  always #5 mclk = ~mclk;
  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: {anode,seg} got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic slot(input string tag, input logic [3:0] an, input logic [7:0] sg, input int chg_at, input logic [4:0] chg_val);
    for (int i = 0; i < 8; i++) begin
      @(negedge mclk);
      check(tag, {bus.anode, bus.seg}, i < 2 ? 12'hFFF : {an, sg});
      if (i == chg_at) bus.sum = chg_val;
    end
  endtask
  task automatic frame(input string tag, input logic [4:0] v, input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] s2, input logic [7:0] s3);
    bus.sum = v;
    slot({tag, "_d0"}, 4'hE, s0, -1, 5'd0);
    slot({tag, "_d1"}, 4'hD, s1, -1, 5'd0);
    slot({tag, "_d2"}, 4'hB, s2, -1, 5'd0);
    slot({tag, "_d3"}, 4'h7, s3, -1, 5'd0);
  endtask
  task automatic startup(input string tag);
    rs = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge mclk);
      check({tag, "_rst"}, {bus.anode, bus.seg}, 12'hFFF);
    end
    rs = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(negedge mclk);
      check({tag, "_pretick"}, {bus.anode, bus.seg}, 12'hFFF);
    end
    frame({tag, "_f0"}, 5'd23, 8'hB0, 8'hA4, 8'hF8, 8'hF9);
  endtask
  initial begin
    bus.sum = 5'd23;
    startup("s1");
    frame("s2", 5'd23, 8'hB0, 8'hA4, 8'hF8, 8'hF9);
    frame("s3", 5'd7, 8'hF8, 8'hFF, 8'hF8, 8'hC0);
    bus.sum = 5'd23;
    slot("s4_d0", 4'hE, 8'hB0, -1, 5'd0);
    slot("s4_d1", 4'hD, 8'hA4, 3, 5'd30);
    slot("s4_d2", 4'hB, 8'hF8, -1, 5'd0);
    slot("s4_d3", 4'h7, 8'hF9, -1, 5'd0);
    frame("s4_next", 5'd30, 8'hC0, 8'hB0, 8'h86, 8'hF9);
    frame("s5_31", 5'd31, 8'hF9, 8'hB0, 8'h8E, 8'hF9);
    frame("s5_0", 5'd0, 8'hC0, 8'hFF, 8'hC0, 8'hC0);
    bus.sum = 5'd23;
    slot("s6_d0", 4'hE, 8'hB0, -1, 5'd0);
    slot("s6_d1", 4'hD, 8'hA4, -1, 5'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge mclk);
      check("s6_d2", {bus.anode, bus.seg}, i < 2 ? 12'hFFF : 12'hBF8);
    end
    #2 rs = 1'b1;
    #1 check("s6_async", {bus.anode, bus.seg}, 12'hFFF);
    startup("s6_restart");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
